// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic             sub_bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_bout;
  logic             sub_ovf;

  modport master (
    output in_valid, sub_a, sub_b, sub_bin, out_ready,
    input  in_ready, out_valid, sub_diff, sub_bout, sub_ovf
  );

  modport slave (
    input  in_valid, sub_a, sub_b, sub_bin, out_ready,
    output in_ready, out_valid, sub_diff, sub_bout, sub_ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell. Operands arrive via a valid/ready handshake
// and the result leaves via a valid/ready handshake. All outputs are registered.
module serial_subtractor #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // minuend shift register
  logic [WIDTH-1:0] b_q, b_d;        // subtrahend shift register
  logic [WIDTH-1:0] res_q, res_d;    // result assembly register, fills from the MSB
  logic             bw_q, bw_d;      // running borrow
  logic             a_sign_q, a_sign_d;
  logic             b_sign_q, b_sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;  // presented result, held until the next DONE
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             bit_diff_s;
  logic             bw_next_s;
  logic             last_bit_s;
  logic             accept_s;

  // One full-subtractor cell on the current operand LSBs and the running borrow.
  always_comb begin
    bit_diff_s = a_q[0] ^ b_q[0] ^ bw_q;
    bw_next_s  = (~a_q[0] & b_q[0]) | (~a_q[0] & bw_q) | (b_q[0] & bw_q);
    last_bit_s = (cnt_q == CW'(WIDTH - 1));
    accept_s   = bus.in_valid & in_ready_q;
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    bw_d        = bw_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (accept_s) begin
          a_d        = bus.sub_a;
          b_d        = bus.sub_b;
          bw_d       = bus.sub_bin;
          a_sign_d   = bus.sub_a[WIDTH-1];
          b_sign_d   = bus.sub_b[WIDTH-1];
          res_d      = {WIDTH{1'b0}};
          cnt_d      = {CW{1'b0}};
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      ST_RUN: begin
        in_ready_d = 1'b0;
        a_d        = {1'b0, a_q[WIDTH-1:1]};
        b_d        = {1'b0, b_q[WIDTH-1:1]};
        res_d      = {bit_diff_s, res_q[WIDTH-1:1]};
        bw_d       = bw_next_s;
        cnt_d      = cnt_q + CW'(1);
        if (last_bit_s) begin
          // The bit computed now is the result MSB, so the output can be built directly.
          diff_d      = {bit_diff_s, res_q[WIDTH-1:1]};
          bout_d      = bw_next_s;
          ovf_d       = (a_sign_q != b_sign_q) & (bit_diff_s != a_sign_q);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          out_valid_d = 1'b0;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          // in_ready rises together with out_valid falling: IDLE accepts on the next edge.
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      res_q       <= {WIDTH{1'b0}};
      bw_q        <= 1'b0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= {WIDTH{1'b0}};
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      bw_q        <= bw_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sub_diff  = diff_q;
  assign bus.sub_bout  = bout_q;
  assign bus.sub_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver pushes arithmetic expectations,
// a negedge monitor pops and compares whenever a result is presented.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           acc;   // edge count sampled just before the accepting edge
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rand_rdy = 1'b0;
  exp_t sb[$];
  exp_t cur;
  bit   prev_v = 1'b0;
  bit   hs_pend = 1'b0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Random backpressure, changed away from the sampling edge.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement readings.
  function automatic exp_t model(input int a, input int b, input int bin);
    exp_t r;
    int d, sa, sb_v, sd;
    d    = a - b - bin;
    sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb_v = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sd   = sa - sb_v - bin;
    r.diff = W'(d & ((1 << W) - 1));
    r.bout = (a < b + bin);
    r.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    r.acc  = 0;
    return r;
  endfunction

  // Monitor: checks every presented result, its latency, stability and handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      hs_pend = 1'b0;
    end else begin
      if (hs_pend) begin
        chk("valid_one_cycle", 32'(bus.out_valid), 32'd0);
        chk("ready_after_done", 32'(bus.in_ready), 32'd1);
      end
      if (bus.out_valid) begin
        chk("in_ready_low_in_done", 32'(bus.in_ready), 32'd0);
        if (!prev_v) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            cur = sb.pop_front();
            chk("diff", 32'(bus.sub_diff), 32'(cur.diff));
            chk("bout", 32'(bus.sub_bout), 32'(cur.bout));
            chk("ovf", 32'(bus.sub_ovf), 32'(cur.ovf));
            chk("latency", 32'(edge_cnt - cur.acc), 32'(W + 1));
          end
        end else if (!hs_pend) begin
          chk("stable_diff", 32'(bus.sub_diff), 32'(cur.diff));
          chk("stable_bout", 32'(bus.sub_bout), 32'(cur.bout));
          chk("stable_ovf", 32'(bus.sub_ovf), 32'(cur.ovf));
        end
        hs_pend = bus.out_ready;
      end else begin
        hs_pend = 1'b0;
      end
      prev_v = bus.out_valid;
    end
  end

  task automatic issue(input int a, input int b, input int bin);
    exp_t e;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.sub_a    = W'(a);
    bus.sub_b    = W'(b);
    bus.sub_bin  = 1'(bin);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus.in_ready) begin
        e     = model(a, b, bin);
        e.acc = edge_cnt;
        sb.push_back(e);
        ok = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      bus.in_valid = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.in_ready && !bus.out_valid) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    bus.out_ready = v;
  endtask

  initial begin
    bit seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sub_a     = '0;
    bus.sub_b     = '0;
    bus.sub_bin   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.sub_diff), 32'd0);
    chk("rst_bout", 32'(bus.sub_bout), 32'd0);
    chk("rst_ovf", 32'(bus.sub_ovf), 32'd0);
    rst_n = 1'b1;
    chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    chk("out_valid_after_rst", 32'(bus.out_valid), 32'd0);

    // Directed arithmetic corners
    set_ready(1'b1);
    issue(9, 3, 0);
    wait_idle();
    issue(3, 9, 0);
    issue(8, 1, 0);
    issue(0, 0, 1);
    issue(15, 15, 0);
    issue(7, 8, 1);
    wait_idle();

    // Backpressure with toggling inputs that must never be accepted
    set_ready(1'b0);
    issue(5, 2, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("bp_result_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.sub_a    = W'($urandom_range(0, 15));
      chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
      chk("bp_diff_held", 32'(bus.sub_diff), 32'd3);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_ready(1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN discards the operation
    issue(6, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_diff", 32'(bus.sub_diff), 32'd0);
    chk("midrst_bout", 32'(bus.sub_bout), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
    issue(6, 1, 0);
    wait_idle();

    // Randomized operands with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    end
    rand_rdy = 1'b0;
    set_ready(1'b1);
    wait_idle();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
